// File: rtl/hfg_rect_if.sv
// Descriptor, integral-RAM and lane bundle between the rectangle dispatcher and its neighbours.
// slave = dispatcher view, master = descriptor source / RAM / consumer view.
interface hfg_rect_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18,
  parameter int REC_W  = 21
) ();
  logic                     rect_valid_i;
  logic                     rect_ready_o;
  logic [4:0]               rect_x_i;
  logic [4:0]               rect_y_i;
  logic [4:0]               rect_w_i;
  logic [4:0]               rect_h_i;
  logic [2:0]               rect_wgt_i;
  logic                     rect_last_i;
  logic                     rd_en_o;
  logic [ADDR_W-1:0]        rd_addr_o;
  logic [DATA_W-1:0]        rd_data_i;
  logic [7:0][REC_W-1:0]    rec_o;
  logic                     wait_o;
  logic                     beat_o;
  logic                     err_o;

  modport slave (
    input  rect_valid_i, rect_x_i, rect_y_i, rect_w_i, rect_h_i, rect_wgt_i, rect_last_i,
    input  rd_data_i,
    output rect_ready_o, rd_en_o, rd_addr_o, rec_o, wait_o, beat_o, err_o
  );

  modport master (
    output rect_valid_i, rect_x_i, rect_y_i, rect_w_i, rect_h_i, rect_wgt_i, rect_last_i,
    output rd_data_i,
    input  rect_ready_o, rd_en_o, rd_addr_o, rec_o, wait_o, beat_o, err_o
  );
endinterface

// File: rtl/hfg_rect_dispatcher.sv
// Reads 4 integral-image corners per rectangle, weights the sum and emits 8-lane beats with oWait.
// Optional out-of-window check enabled by defining HFG_RECT_BOUND_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a descriptor
// FETCH | issuing corner reads A,B,C,D
// CALC  | D arrives, weighted sum written to the next slot
// EMIT  | one beat on the lanes, slots clear
module hfg_rect_dispatcher #(
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18,
  parameter int REC_W  = 21
) (
  input  logic        iClk,
  input  logic        iReset_n,
  hfg_rect_if.slave   bus
);

  if (ADDR_W < $clog2((IMG_W + 1) * (IMG_H + 1))) begin : g_addr_chk
    $error("ADDR_W too small for the integral window");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CALC, S_EMIT} state_t;

  state_t                  state_q;
  logic [4:0]              x_q, y_q;
  logic [5:0]              x2_q, y2_q;
  logic [2:0]              wgt_q;
  logic                    last_q;
  logic                    oob_q;
  logic [2:0]              rd_idx_q;
  logic [DATA_W-1:0]       acc_q;
  logic [3:0]              cnt_q;
  logic [7:0][REC_W-1:0]   slot_q;
  logic                    ready_q;
  logic                    rd_en_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic [7:0][REC_W-1:0]   rec_q;
  logic                    wait_q;
  logic                    beat_q;
  logic                    err_q;

  logic [5:0]              hs_x2, hs_y2;
  logic                    hs_oob;
  logic [DATA_W-1:0]       s_d;
  logic [REC_W-1:0]        s_ext, wgt_ext, v_d;
  logic [7:0][REC_W-1:0]   slot_d;

  function automatic logic [ADDR_W-1:0] corner(input logic [5:0] cx, input logic [5:0] cy);
    int lin;
    lin = int'(cy) * (IMG_W + 1) + int'(cx);
    return lin[ADDR_W-1:0];
  endfunction

  assign hs_x2 = {1'b0, bus.rect_x_i} + {1'b0, bus.rect_w_i};
  assign hs_y2 = {1'b0, bus.rect_y_i} + {1'b0, bus.rect_h_i};

`ifdef HFG_RECT_BOUND_CHECK_EN
  assign hs_oob = (hs_x2 > 6'(IMG_W)) || (hs_y2 > 6'(IMG_H));
`else
  assign hs_oob = 1'b0;
`endif

  // D arrives on the read bus during CALC; acc_q already holds A-B-C.
  assign s_d     = acc_q + bus.rd_data_i;
  assign s_ext   = {{(REC_W-DATA_W){1'b0}}, s_d};
  assign wgt_ext = {{(REC_W-3){wgt_q[2]}}, wgt_q};
  assign v_d     = oob_q ? '0 : s_ext * wgt_ext;

  always_comb begin
    slot_d              = slot_q;
    slot_d[cnt_q[2:0]]  = v_d;
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      wgt_q     <= '0;
      last_q    <= 1'b0;
      oob_q     <= 1'b0;
      rd_idx_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      slot_q    <= '0;
      ready_q   <= 1'b1;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rec_q     <= '0;
      wait_q    <= 1'b0;
      beat_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.rect_valid_i && ready_q) begin
            x_q       <= bus.rect_x_i;
            y_q       <= bus.rect_y_i;
            x2_q      <= hs_x2;
            y2_q      <= hs_y2;
            wgt_q     <= bus.rect_wgt_i;
            last_q    <= bus.rect_last_i;
            oob_q     <= hs_oob;
            if (hs_oob) err_q <= 1'b1;
            ready_q   <= 1'b0;
            rd_en_q   <= ~hs_oob;
            rd_addr_q <= corner({1'b0, bus.rect_x_i}, {1'b0, bus.rect_y_i});
            rd_idx_q  <= 3'd1;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          rd_idx_q <= rd_idx_q + 3'd1;
          case (rd_idx_q)
            3'd1: rd_addr_q <= corner(x2_q, {1'b0, y_q});
            3'd2: begin
              acc_q     <= bus.rd_data_i;
              rd_addr_q <= corner({1'b0, x_q}, y2_q);
            end
            3'd3: begin
              acc_q     <= acc_q - bus.rd_data_i;
              rd_addr_q <= corner(x2_q, y2_q);
            end
            3'd4: begin
              acc_q   <= acc_q - bus.rd_data_i;
              rd_en_q <= 1'b0;
              state_q <= S_CALC;
            end
            default: ;
          endcase
        end
        S_CALC: begin
          slot_q <= slot_d;
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'd7 || last_q) begin
            rec_q   <= slot_d;
            beat_q  <= 1'b1;
            wait_q  <= ~last_q;
            state_q <= S_EMIT;
          end else begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_EMIT: begin
          rec_q   <= '0;
          beat_q  <= 1'b0;
          slot_q  <= '0;
          cnt_q   <= '0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rect_ready_o = ready_q;
  assign bus.rd_en_o      = rd_en_q;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.rec_o        = rec_q;
  assign bus.wait_o       = wait_q;
  assign bus.beat_o       = beat_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_hfg_rect_dispatcher.sv
// Directed bench for hfg_rect_dispatcher: RAM model, read-address and beat scoreboards.
module tb_hfg_rect_dispatcher;
  localparam int IMG_W = 24, IMG_H = 24, ADDR_W = 10, DATA_W = 18, REC_W = 21;

  typedef struct packed {
    logic [7:0][REC_W-1:0] rec;
    logic                  wt;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hfg_rect_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REC_W(REC_W)) bus ();

  hfg_rect_dispatcher #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REC_W(REC_W)
  ) dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (bus)
  );

  logic [DATA_W-1:0]     ram [0:1023];
  int                    checks = 0;
  int                    failures = 0;
  int                    cyc = 0;
  beat_t                 sb[$];
  logic [ADDR_W-1:0]     addr_q[$];
  logic [7:0][REC_W-1:0] m_slot;
  int                    m_cnt;
  logic                  exp_wait, exp_err;
  logic [REC_W-1:0]      comp_sum;
  bit                    mon_en = 1'b0;
  beat_t                 mon_e;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= ram[bus.rd_addr_o];

  task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rd_en_o) begin
        if (addr_q.size() == 0) chk("rd_extra", bus.rd_en_o, 1'b0);
        else chk("rd_addr", bus.rd_addr_o, addr_q.pop_front());
      end
      if (bus.beat_o) begin
        if (sb.size() == 0) chk("beat_extra", bus.beat_o, 1'b0);
        else begin
          mon_e = sb.pop_front();
          chk("lanes", bus.rec_o, mon_e.rec);
          chk("wait_beat", bus.wait_o, mon_e.wt);
          exp_wait = mon_e.wt;
          for (int i = 0; i < 8; i++) comp_sum = comp_sum + bus.rec_o[i];
        end
      end else begin
        chk("lanes_idle", bus.rec_o, '0);
        chk("wait_gap", bus.wait_o, exp_wait);
      end
      chk("err", bus.err_o, exp_err);
    end
  end

  function automatic logic [ADDR_W-1:0] lin(input int x, input int y);
    return ADDR_W'(y * (IMG_W + 1) + x);
  endfunction

  task automatic set_corners(input int x, input int y, input int w, input int h,
                             input int a, input int b, input int c, input int d);
    ram[lin(x, y)]         = DATA_W'(a);
    ram[lin(x + w, y)]     = DATA_W'(b);
    ram[lin(x, y + h)]     = DATA_W'(c);
    ram[lin(x + w, y + h)] = DATA_W'(d);
  endtask

  task automatic flush_model();
    sb.delete();
    addr_q.delete();
    m_slot   = '0;
    m_cnt    = 0;
    exp_wait = 1'b0;
    exp_err  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic send_rect(input int x, input int y, input int w, input int h, input int wgt,
                           input bit last, input bit hold, output int hs);
    bit                oob;
    logic [DATA_W-1:0] s;
    logic [REC_W-1:0]  v;
    beat_t             e;
    longint            p;
    bus.rect_x_i    = 5'(x);
    bus.rect_y_i    = 5'(y);
    bus.rect_w_i    = 5'(w);
    bus.rect_h_i    = 5'(h);
    bus.rect_wgt_i  = 3'(wgt);
    bus.rect_last_i = last;
    bus.rect_valid_i = 1'b1;
    hs = -1;
    for (int k = 0; k < 100; k++) begin
      if (bus.rect_ready_o) begin
        hs = 0;
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) begin
      chk("hs_timeout", bus.rect_ready_o, 1'b1);
      bus.rect_valid_i = 1'b0;
      return;
    end
`ifdef HFG_RECT_BOUND_CHECK_EN
    oob = (x + w > IMG_W) || (y + h > IMG_H);
`else
    oob = 1'b0;
`endif
    if (!oob) begin
      addr_q.push_back(lin(x, y));
      addr_q.push_back(lin(x + w, y));
      addr_q.push_back(lin(x, y + h));
      addr_q.push_back(lin(x + w, y + h));
    end
    s = DATA_W'(int'(ram[lin(x + w, y + h)]) - int'(ram[lin(x + w, y)])
                - int'(ram[lin(x, y + h)]) + int'(ram[lin(x, y)]));
    p = longint'(s) * longint'(wgt);
    v = oob ? '0 : REC_W'(p);
    m_slot[m_cnt] = v;
    m_cnt++;
    if (m_cnt == 8 || last) begin
      e.rec = m_slot;
      e.wt  = ~last;
      sb.push_back(e);
      m_slot = '0;
      m_cnt  = 0;
    end
    @(posedge clk);
    if (oob) exp_err = 1'b1;
    @(negedge clk);
    hs = cyc;
    if (!hold) bus.rect_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && addr_q.size() == 0 && bus.rect_ready_o) break;
    end
    chk({tag, "_beats_left"}, sb.size(), 0);
    chk({tag, "_reads_left"}, addr_q.size(), 0);
    chk({tag, "_idle_ready"}, bus.rect_ready_o, 1'b1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.rect_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.rect_ready_o, 1'b1);
    chk("rst_rd_en", bus.rd_en_o, 1'b0);
    chk("rst_rd_addr", bus.rd_addr_o, '0);
    chk("rst_rec", bus.rec_o, '0);
    chk("rst_wait", bus.wait_o, 1'b0);
    chk("rst_beat", bus.beat_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    rst_n = 1'b1;
    flush_model();
    mon_en = 1'b1;
  endtask

  task automatic t1_feature();
    int hs;
    set_corners(0, 0, 2, 2, 0, 0, 0, 40);
    comp_sum = '0;
    send_rect(0, 0, 2, 2, 1, 1'b1, 1'b0, hs);
    drain("t1");
    chk("t1_composed", comp_sum, 21'd40);
  endtask

  initial begin
    int hs, hs_prev;
    int wg [3];
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    bus.rect_valid_i = 1'b0;
    bus.rect_x_i = '0; bus.rect_y_i = '0; bus.rect_w_i = '0; bus.rect_h_i = '0;
    bus.rect_wgt_i = '0; bus.rect_last_i = 1'b0;
    flush_model();
    comp_sum = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // T1: single rectangle, reads at 0,2,50,52
    t1_feature();

    // T2: three rectangles in one beat, weights -1,2,2
    wg[0] = -1; wg[1] = 2; wg[2] = 2;
    comp_sum = '0;
    for (int i = 0; i < 3; i++) begin
      set_corners(0, 2 * i, 1, 1, 5, 1, 2, 8);
      send_rect(0, 2 * i, 1, 1, wg[i], i == 2, 1'b0, hs);
    end
    drain("t2");
    chk("t2_composed", comp_sum, 21'd30);

    // T3: ten rectangles, two beats with oWait held through the gap
    comp_sum = '0;
    for (int i = 0; i < 10; i++) begin
      set_corners(0, 2 * i, 1, 1, 1, 0, 0, 0);
      send_rect(0, 2 * i, 1, 1, 1, i == 9, 1'b0, hs);
    end
    drain("t3");
    chk("t3_composed", comp_sum, 21'd10);

    // T4: reset during FETCH of rect 5, then a fresh feature
    for (int i = 0; i < 5; i++) begin
      set_corners(0, 2 * i, 1, 1, 3, 1, 1, 2);
      send_rect(0, 2 * i, 1, 1, 1, 1'b0, 1'b0, hs);
    end
    @(negedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    t1_feature();

    // random data and weights
    comp_sum = '0;
    for (int i = 0; i < 4; i++) begin
      set_corners(2 + i, 3 * i, 3, 2, int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)),
                  int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)));
      send_rect(2 + i, 3 * i, 3, 2, int'($urandom_range(0, 7)) - 4, i == 3, 1'b0, hs);
    end
    drain("rnd");

    // T5: out-of-window rectangles, then a legal feature with err still sticky
    set_corners(20, 0, 6, 1, 100, 30, 20, 7);
    send_rect(20, 0, 6, 1, 1, 1'b0, 1'b0, hs);
    set_corners(0, 20, 1, 5, 9, 2, 3, 4);
    send_rect(0, 20, 1, 5, 2, 1'b1, 1'b0, hs);
    drain("t5");
    t1_feature();
`ifdef HFG_RECT_BOUND_CHECK_EN
    chk("t5_err_sticky", bus.err_o, 1'b1);
`else
    chk("t5_err_off", bus.err_o, 1'b0);
`endif
    do_reset();

    // T6: valid held high, one handshake per 6 cycles, wrap case on the last rect
    hs_prev = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3)
        set_corners(0, 2 * i, 1, 1, int'($urandom_range(0, 1000)), 0, 0, int'($urandom_range(0, 1000)));
      else
        set_corners(0, 2 * i, 1, 1, 262143, 0, 0, 0);
      send_rect(0, 2 * i, 1, 1, (i < 3) ? i + 1 : -4, i == 3, i < 3, hs);
      if (i > 0) chk("t6_hs_spacing", hs - hs_prev, 6);
      hs_prev = hs;
    end
    drain("t6");

    do_reset();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
